// File: rtl/sprite_fetch_sched.sv
// sprite_fetch_sched: fetches one sprite row into a line buffer during
// horizontal blanking and streams it out by column in active video.
`timescale 1ns/1ps
module sprite_fetch_sched #(
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16,
  parameter int V_TOTAL  = 525,
  parameter int ROM_LAT  = 1
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  input  logic        line_tick,
  input  logic [9:0]  line_num,
  input  logic        disp_ena,
  input  logic [9:0]  column,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  output logic [7:0]  rom_addr,
  input  logic [11:0] rom_data,
  output logic        pix_valid,
  output logic [11:0] pix_color,
  output logic        line_ready,
  output logic        busy,
  output logic        overrun
);

  localparam int XW = $clog2(SPRITE_W);
  localparam int YW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam int DW = $clog2(ROM_LAT + 2);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t state;
  state_t state_n;

  logic [10:0]   t_line;
  logic [10:0]   y_lo;
  logic [10:0]   y_hi;
  logic [10:0]   col_w;
  logic [10:0]   x_lo;
  logic [10:0]   x_hi;
  logic          hit;
  logic          in_win;
  logic          de_q;
  logic          de_rise;
  logic          abort;
  logic          load;
  logic          issue;
  logic          done;
  logic [XW-1:0] idx;
  logic [XW-1:0] col_off;
  logic [YW-1:0] srow;
  logic [YW-1:0] row_off;
  logic [9:0]    lx;
  logic [DW-1:0] drain_cnt;

  logic [ROM_LAT:0] wr_vld;
  logic [XW-1:0]    wr_idx [ROM_LAT+1];
  logic [11:0]      line_buf [SPRITE_W];

  // Target is the line after the tick; compared in 11 bits so the
  // bottom edge of the sprite never wraps.
  always_comb begin
    t_line = (line_num == 10'(V_TOTAL - 1)) ? 11'd0
           : {1'b0, line_num} + 11'd1;
    y_lo = {1'b0, sprite_y};
    y_hi = y_lo + 11'(SPRITE_H - 1);
    hit = (t_line >= y_lo) && (t_line <= y_hi);
    row_off = t_line[YW-1:0] - sprite_y[YW-1:0];
  end

  assign de_rise = disp_ena & ~de_q;
  assign busy    = (state != IDLE);
  assign abort   = de_rise & busy;

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (line_tick) begin
      state_n = hit ? FETCH : IDLE;
    end else if (abort) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        FETCH: if (idx == XW'(SPRITE_W - 1)) state_n = DRAIN;
        DRAIN: if (drain_cnt == DW'(ROM_LAT)) state_n = IDLE;
        default: state_n = state;
      endcase
    end
  end

  always_comb begin
    load  = 1'b0;
    issue = 1'b0;
    done  = 1'b0;
    if (line_tick) begin
      load = hit;
    end else if (!abort) begin
      issue = (state == FETCH);
      done  = (state == DRAIN) && (drain_cnt == DW'(ROM_LAT));
    end
  end

  // The first address goes out on the tick edge so reads run back to back.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr   <= '0;
      idx        <= '0;
      srow       <= '0;
      lx         <= '0;
      drain_cnt  <= '0;
      line_ready <= 1'b0;
      overrun    <= 1'b0;
      de_q       <= 1'b0;
    end else begin
      de_q <= disp_ena;
      if (abort) overrun <= 1'b1;
      if (line_tick)  line_ready <= 1'b0;
      else if (done)  line_ready <= 1'b1;
      if (load) begin
        lx       <= sprite_x;
        srow     <= row_off;
        rom_addr <= 8'({row_off, {XW{1'b0}}});
        idx      <= XW'(1);
      end else if (issue) begin
        rom_addr <= 8'({srow, idx});
        idx      <= idx + XW'(1);
      end
      if (state == DRAIN) drain_cnt <= drain_cnt + DW'(1);
      else                drain_cnt <= '0;
    end
  end

  // Column tags follow the read latency; a new tick drops in-flight data.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_vld <= '0;
      for (int j = 0; j <= ROM_LAT; j++) wr_idx[j] <= '0;
    end else begin
      wr_vld[0] <= load | issue;
      wr_idx[0] <= load ? '0 : idx;
      for (int j = 1; j <= ROM_LAT; j++) begin
        wr_vld[j] <= wr_vld[j-1] & ~line_tick;
        wr_idx[j] <= wr_idx[j-1];
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (wr_vld[ROM_LAT]) line_buf[wr_idx[ROM_LAT]] <= rom_data;
  end

  always_comb begin
    col_w   = {1'b0, column};
    x_lo    = {1'b0, lx};
    x_hi    = x_lo + 11'(SPRITE_W - 1);
    in_win  = disp_ena && line_ready && (col_w >= x_lo) && (col_w <= x_hi);
    col_off = column[XW-1:0] - lx[XW-1:0];
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_valid <= 1'b0;
      pix_color <= '0;
    end else begin
      pix_valid <= in_win;
      pix_color <= in_win ? line_buf[col_off] : '0;
    end
  end

endmodule

// File: doc/sprite_fetch_sched.md
# sprite_fetch_sched

Line-based fetch scheduler for the 16x16 sprite colour memory (256 x 12-bit, registered read) that sits between the VGA timing generator and the pixel mux. During each horizontal blanking interval it decides whether the next display line crosses the sprite and, if so, sequences the 16 memory reads for that sprite row into an internal line buffer. During active video it streams buffered pixels by column. The memory address port is then driven only in blanking, never combinationally from `column`/`row`.

## Interface
- `SPRITE_W`, 16: sprite width in pixels. Power of two.
- `SPRITE_H`, 16: sprite height in lines.
- `V_TOTAL`, 525: total lines per frame, blanking included.
- `ROM_LAT`, 1: memory read latency in cycles.
- `pixel_clk`  in  1: pixel clock, 25 MHz; all logic on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `line_tick`  in  1: one-cycle pulse at the first blanking cycle of every line (all `V_TOTAL` lines).
- `line_num`  in  10: current line 0..V_TOTAL-1, stable while `line_tick`=1.
- `disp_ena`  in  1: active-video qualifier.
- `column`  in  10: current active column.
- `sprite_x`  in  10: sprite left column, already saturated.
- `sprite_y`  in  10: sprite top line, already saturated.
- `rom_addr`  out  8: memory address.
- `rom_data`  in  12: memory read data, {R,G,B} 4 bits each.
- `pix_valid`  out  1: sprite pixel present this cycle.
- `pix_color`  out  12: sprite pixel colour.
- `line_ready`  out  1: buffer holds the current line's sprite row.
- `busy`  out  1: FETCH or DRAIN in progress.
- `overrun`  out  1: sticky; a fetch did not finish before active video.

## Operation
- Target line: t = (line_num == V_TOTAL-1) ? 0 : line_num+1. Compare in 11 bits; sprite_y+SPRITE_H-1 must not wrap.
- FSM states:
  - IDLE: on `line_tick`, clear `line_ready`. If sprite_y <= t <= sprite_y+SPRITE_H-1: latch lx=sprite_x, srow=t-sprite_y, i=0, go FETCH. Otherwise stay in IDLE.
  - FETCH: drive rom_addr=srow*SPRITE_W+i, i++. After the i=SPRITE_W-1 issue, go DRAIN.
  - DRAIN: wait ROM_LAT cycles for the last data, then set `line_ready`=1 and go IDLE.
- Buffer write: rom_data is captured into buf[i_delayed], where i_delayed is i delayed by ROM_LAT cycles.
- Pixel stream: when disp_ena && line_ready && lx <= column <= lx+SPRITE_W-1 (compare in 11 bits), pix_valid=1 and pix_color=buf[column-lx]. Otherwise pix_valid=0 and pix_color=0.
- `sprite_x`/`sprite_y` changes mid-line do not affect the current line; they take effect at the next `line_tick`.
- `line_tick` while busy: restart from IDLE evaluation with the new target line; the old fetch is abandoned.
- `disp_ena` rising while busy: set `overrun` (sticky until reset), abort to IDLE, keep line_ready=0.
- rom_addr holds its last value outside FETCH.
- Reset (asynchronous, including mid-fetch): FSM=IDLE, rom_addr=0, pix_valid=0, pix_color=0, line_ready=0, busy=0, overrun=0. Buffer contents are don't-care.

## Timing
- `line_tick` at cycle T: first rom_addr at T+1, last at T+SPRITE_W, line_ready=1 at T+SPRITE_W+ROM_LAT+1. That is cycle T+18 with defaults, well inside 160 blanking cycles.
- busy=1 from T+1 through the cycle before line_ready rises.
- Pixel path latency is 1 cycle: pix_valid/pix_color are registered from the previous cycle's column/disp_ena. The integrator delays col-based decisions to match.
- One memory read per cycle, no bubbles. At most one fetch per line.

## Test plan
- Hit: sprite_y=100, sprite_x=200, ROM[i]=i, line_tick with line_num=99 -> rom_addr 0..15 on consecutive cycles, line_ready at +18. On line 100, pix_valid for columns 200..215 only, pix_color 0x000..0x00F.
- Row offset and miss: sprite_y=100, tick with line_num=114 -> addresses 240..255. Tick with line_num=115 -> no fetch, line_ready=0, pix_valid stays 0.
- Frame wrap: sprite_y=0, tick with line_num=524 -> fetch of srow 0 (addr 0..15). Tick with line_num=479, sprite_y=464 -> addresses 0..15 for line 480 not fetched (480 > 479).
- Right edge: sprite_x=624 -> pix_valid on columns 624..639 only, no 10-bit wrap to columns 0..15.
- Abort: assert disp_ena 5 cycles after line_tick -> overrun=1 and stays 1, line_ready=0, pix_valid=0 for that line. Reset clears overrun.
- Async reset mid-FETCH (i=7) -> all outputs 0 immediately, without a clock edge. The next line_tick restarts from addr srow*16.
